peripheral_msi_responder_tl: RTL and testbench
==============================================

PERIPHERAL_MSI_RESPONDER_TL -- requirements
Module: peripheral_msi_responder_tl

Interface
REQ-001 SHALL have parameter PLEN, default 64, address width.
REQ-002 SHALL have parameter XLEN, default 64, data width (32 or 64).
REQ-003 SHALL have parameter DEPTH, default 256, memory depth in XLEN-bit words.
REQ-004 SHALL have parameter WAIT_STATES, default 1, inserted wait cycles per transfer (0..15).
REQ-005 Ports SHALL be (clock and reset first): one clock; reset asynchronous, active-high.
- HCLK  in  1  clock, all state on rising edge.
- HRESET  in  1  asynchronous active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  PLEN  byte address.
- HWDATA  in  XLEN  write data (data phase).
- HRDATA  out  XLEN  read data.
- HWRITE  in  1  1=write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type, ignored.
- HPROT  in  4  protection, ignored.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HMASTLOCK  in  1  lock, ignored.
- HREADY  in  1  bus ready (previous transfer completing).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-006 Address phase SHALL be accepted only when HSEL=1, HREADY=1, HTRANS in {NONSEQ,SEQ}; HADDR, HWRITE, HSIZE latched that edge.
REQ-007 IDLE/BUSY or HSEL=0 with HREADY=1 SHALL get zero-wait OKAY response; no memory access.
REQ-008 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-009 IDLE: HREADYOUT=1, HRESP=0; valid accepted transfer -> WAIT if WAIT_STATES>0, else DATA; error-qualified transfer -> ERR1.
REQ-010 WAIT: HREADYOUT=0, HRESP=0; 4-bit counter loaded with WAIT_STATES-1 at acceptance, decrements each cycle; at 0 -> DATA.
REQ-011 DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle; next state per REQ-009 on the new address phase (back-to-back pipelining, no bubble).
REQ-012 ERR1: HREADYOUT=0, HRESP=1, one cycle -> ERR2; ERR2: HREADYOUT=1, HRESP=1, then per REQ-009.
REQ-013 Write SHALL commit at the rising edge ending DATA, using HWDATA sampled that edge; only byte lanes selected by latched HSIZE and HADDR[log2(XLEN/8)-1:0] written.
REQ-014 Read: HRDATA SHALL equal mem[latched word index] during DATA; 0 in all other states.
REQ-015 Word index = HADDR[log2(XLEN/8)+log2(DEPTH)-1 : log2(XLEN/8)]; read immediately after write to same address SHALL return the new data.
REQ-016 Address-phase sampling SHALL NOT occur while HREADYOUT=0 (WAIT, ERR1).

Reset
REQ-017 HRESET=1 SHALL force IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, counter=0, latched controls cleared, immediately (async).
REQ-018 Reset mid-WAIT/DATA SHALL discard the pending write; memory contents SHALL NOT be reset.

Configuration
REQ-019 Macro PERIPHERAL_MSI_RESPONDER_ERR_EN defined: transfer is error-qualified if HSIZE > log2(XLEN/8), address misaligned to HSIZE, or byte address >= DEPTH*XLEN/8; error transfers take ERR1/ERR2, no memory access.
REQ-020 Macro undefined: no ERROR responses ever (HRESP tied 0, ERR states absent); index wraps modulo DEPTH; oversize HSIZE treated as full word.

Structure
REQ-021 Package peripheral_msi_pkg SHALL hold HTRANS_*, HSIZE_*, HRESP_OKAY/ERROR constants and the FSM state typedef.
REQ-022 Storage SHALL be sub-module peripheral_msi_responder_ram (byte-enable write, async read, DEPTH x XLEN).

Verification
REQ-023 WAIT_STATES=1: write NONSEQ 0x10 64-bit 0xDEADBEEF_CAFEF00D, then read 0x10 -> one HREADYOUT=0 cycle each, HRDATA=0xDEADBEEF_CAFEF00D, HRESP=0.
REQ-024 WAIT_STATES=0: back-to-back writes 0x0,0x8,0x10 then reads -> HREADYOUT constantly 1, data returned in order.
REQ-025 Byte write HSIZE=0 to 0x23 data 0xAB in lane 3 over word 0 at 0x20 -> read 0x20 returns 0x0000_0000_AB00_0000.
REQ-026 ERR_EN defined: read 0x800 (DEPTH=256) -> ERR1 (HREADYOUT=0,HRESP=1) then ERR2 (HREADYOUT=1,HRESP=1); misaligned word at 0x4 -> same.
REQ-027 HRESET asserted during WAIT of write to 0x18 -> outputs reset values at once; subsequent read 0x18 returns prior contents.
REQ-028 HTRANS=BUSY and HSEL=0 cycles interleaved -> OKAY, HREADYOUT=1, memory unchanged.

Source files
------------

// File: rtl/peripheral_msi_pkg.sv
// Shared AHB-lite encodings and FSM state type for the MSI responder.
package peripheral_msi_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } msi_state_e;

endpackage

// File: rtl/peripheral_msi_responder_ram.sv
// DEPTH x XLEN storage: byte-enable synchronous write, asynchronous read, never reset.
module peripheral_msi_responder_ram
    import peripheral_msi_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [XLEN/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [XLEN-1:0]          rdata
);

    localparam int unsigned NB = XLEN / 8;

    logic [XLEN-1:0] mem [DEPTH];

    // Byte-lane write; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/peripheral_msi_responder_tl.sv
// AHB-lite memory responder with configurable wait states.
// Optional error checking (size/alignment/range) enabled by PERIPHERAL_MSI_RESPONDER_ERR_EN.
module peripheral_msi_responder_tl
    import peripheral_msi_pkg::*;
#(
    parameter int PLEN        = 64,
    parameter int XLEN        = 64,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    output logic [XLEN-1:0] HRDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP
);

    localparam int unsigned NB        = XLEN / 8;
    localparam int unsigned LG        = $clog2(NB);
    localparam int unsigned IW        = $clog2(DEPTH);
    localparam int unsigned MEM_BYTES = DEPTH * NB;

    // Low-offset bits that must be zero for a transfer of the given size.
    function automatic logic [LG-1:0] size_mask(input logic [2:0] sz);
        logic [LG-1:0] m;
        m = '0;
        for (int i = 0; i < int'(LG); i++) begin
            m[i] = (i < int'(sz));
        end
        return m;
    endfunction

    // Lanes of the naturally aligned block containing off; oversize sizes cover the word.
    function automatic logic [NB-1:0] lane_enables(input logic [2:0] sz, input logic [LG-1:0] off);
        logic [LG-1:0] m;
        logic [NB-1:0] be;
        m  = size_mask(sz);
        be = '0;
        for (int b = 0; b < int'(NB); b++) begin
            be[b] = ((LG'(b) & ~m) == (off & ~m));
        end
        return be;
    endfunction

    msi_state_e      state;
    logic [3:0]      wait_cnt;
    logic [IW-1:0]   idx_q;
    logic [LG-1:0]   off_q;
    logic [2:0]      size_q;
    logic            write_q;

    logic            accept_c;
    logic            addr_err_c;
    logic            wr_commit_c;
    logic [NB-1:0]   wr_be_c;
    logic [IW-1:0]   rd_idx_c;
    logic            rd_go_c;
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] rd_fwd_c;
    logic            unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR};

    // Address phase is only sampled while this slave is presenting ready.
    assign accept_c = HSEL & HREADY & HTRANS[1] & HREADYOUT;

`ifdef PERIPHERAL_MSI_RESPONDER_ERR_EN
    assign addr_err_c = (HSIZE > 3'(LG))
                     || ((HADDR[LG-1:0] & size_mask(HSIZE)) != '0)
                     || (HADDR >= PLEN'(MEM_BYTES));
`else
    assign addr_err_c = 1'b0;
`endif

    assign wr_commit_c = (state == ST_DATA) && write_q;
    assign wr_be_c     = lane_enables(size_q, off_q);

    // Word whose data will be presented in the next DATA cycle.
    assign rd_idx_c = (state == ST_WAIT) ? idx_q : HADDR[LG+IW-1:LG];
    assign rd_go_c  = (state == ST_WAIT) ? ((wait_cnt == 4'd0) && !write_q)
                                         : (accept_c && !addr_err_c && !HWRITE && (WAIT_STATES == 0));

    peripheral_msi_responder_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (HCLK),
        .we    (wr_commit_c),
        .be    (wr_be_c),
        .waddr (idx_q),
        .wdata (HWDATA),
        .raddr (rd_idx_c),
        .rdata (ram_rdata)
    );

    // Forward bytes of a write committing on the same edge a read is launched.
    always_comb begin
        rd_fwd_c = ram_rdata;
        for (int b = 0; b < int'(NB); b++) begin
            if (wr_commit_c && (idx_q == rd_idx_c) && wr_be_c[b]) begin
                rd_fwd_c[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    // Transfer FSM with registered handshake and read data.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            idx_q     <= '0;
            off_q     <= '0;
            size_q    <= 3'd0;
            write_q   <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
        end else begin
            HRDATA <= rd_go_c ? rd_fwd_c : '0;
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_DATA;
                        HREADYOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
`ifdef PERIPHERAL_MSI_RESPONDER_ERR_EN
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
`endif
                default: begin
                    if (accept_c) begin
                        idx_q   <= HADDR[LG+IW-1:LG];
                        off_q   <= HADDR[LG-1:0];
                        size_q  <= HSIZE;
                        write_q <= HWRITE;
                        if (addr_err_c) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            wait_cnt  <= 4'(WAIT_STATES - 1);
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_OKAY;
                        end else begin
                            state     <= ST_DATA;
                            HREADYOUT <= 1'b1;
                            HRESP     <= HRESP_OKAY;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_msi_responder_tl.sv
// Bench: two responders (1 and 0 wait states) driven by a pipelined AHB master,
// checked against a byte-level memory model.
module tb_peripheral_msi_responder_tl;
    import peripheral_msi_pkg::*;

    typedef struct {
        logic [63:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [63:0] data;
        int          gap;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b1;
    logic        h_sel = 1'b0;
    logic [63:0] h_addr = '0;
    logic [63:0] h_wdata = '0;
    logic        h_write = 1'b0;
    logic [2:0]  h_size = 3'd0;
    logic [1:0]  h_trans = HTRANS_IDLE;

    logic        hsel0, hsel1, ro0, ro1, rs0, rs1;
    logic [63:0] rd0, rd1;

    logic [63:0] mem_m [2][256];
    op_t         ops[$];
    logic [63:0] rd_log[$];
    logic [63:0] last_rdata;
    int          stall_total;
    int          n_tests = 0;
    int          n_fail  = 0;

    assign hsel0 = h_sel & (sel == 1'b0);
    assign hsel1 = h_sel & (sel == 1'b1);

    always #5 clk = ~clk;

    peripheral_msi_responder_tl #(.PLEN(64), .XLEN(64), .DEPTH(256), .WAIT_STATES(1)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel1), .HADDR(h_addr), .HWDATA(h_wdata), .HRDATA(rd1),
        .HWRITE(h_write), .HSIZE(h_size), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(h_trans),
        .HMASTLOCK(1'b0), .HREADY(ro1), .HREADYOUT(ro1), .HRESP(rs1)
    );

    peripheral_msi_responder_tl #(.PLEN(64), .XLEN(64), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(h_addr), .HWDATA(h_wdata), .HRDATA(rd0),
        .HWRITE(h_write), .HSIZE(h_size), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(h_trans),
        .HMASTLOCK(1'b0), .HREADY(ro0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input op_t o);
`ifdef PERIPHERAL_MSI_RESPONDER_ERR_EN
        return (o.size > 3'd3) || ((o.addr % (64'd1 << o.size)) != 64'd0) || (o.addr >= 64'd2048);
`else
        return (o.size == 3'd7) && (o.size != 3'd7);
`endif
    endfunction

    function automatic int word_of(input op_t o);
        return int'((o.addr / 64'd8) % 64'd256);
    endfunction

    // Apply a completed write: the naturally aligned block of 2^size bytes holding addr.
    function automatic void model_write(input op_t o);
        int n, base, w, lane;
        n    = 1 << ((o.size > 3'd3) ? 3 : int'(o.size));
        base = (int'(o.addr % 64'd8) / n) * n;
        w    = word_of(o);
        for (int k = 0; k < n; k++) begin
            lane = base + k;
            mem_m[sel][w][lane*8 +: 8] = o.data[lane*8 +: 8];
        end
    endfunction

    task automatic push(input logic [63:0] a, input logic wr, input logic [2:0] sz,
                        input logic [63:0] d, input int gap);
        op_t o;
        o.addr = a; o.wr = wr; o.size = sz; o.data = d; o.gap = gap;
        ops.push_back(o);
    endtask

    task automatic drive_gap(input op_t o);
        case ($urandom_range(0, 2))
            0:       begin h_sel = 1'b1; h_trans = HTRANS_IDLE; end
            1:       begin h_sel = 1'b1; h_trans = HTRANS_BUSY; end
            default: begin h_sel = 1'b0; h_trans = HTRANS_NONSEQ; end
        endcase
        h_addr = o.addr; h_write = 1'b1; h_size = o.size;
    endtask

    // Pipelined master: address phase of the next op overlaps the data phase of the current one.
    task automatic run_ops();
        op_t cur, dp;
        bit have_cur = 0, dp_v = 0, stalled = 0, addr_xfer = 0;
        int gap = 0, stalls = 0, cycles = 0;
        logic rdy, rsp;
        logic [63:0] rd;
        stall_total = 0;
        while ((ops.size() > 0 || have_cur || dp_v) && cycles < 20000) begin
            cycles++;
            if (!stalled) begin
                if (!have_cur && ops.size() > 0) begin
                    cur = ops.pop_front(); gap = cur.gap; have_cur = 1;
                end
                addr_xfer = 0;
                if (have_cur && gap > 0) begin
                    drive_gap(cur); gap--;
                end else if (have_cur) begin
                    h_sel = 1'b1; h_trans = HTRANS_NONSEQ; h_addr = cur.addr;
                    h_write = cur.wr; h_size = cur.size; addr_xfer = 1;
                end else begin
                    h_sel = 1'b1; h_trans = HTRANS_IDLE;
                end
                h_wdata = (dp_v && dp.wr) ? dp.data : {$urandom, $urandom};
            end
            @(negedge clk);
            rdy = sel ? ro1 : ro0;
            rsp = sel ? rs1 : rs0;
            rd  = sel ? rd1 : rd0;
            if (dp_v) begin
                if (!rdy) begin
                    stalls++; stall_total++;
                    check("stall_resp", 64'(rsp), 64'(is_err(dp)));
                    check("stall_rdata", rd, 64'd0);
                end else begin
                    check("xfer_waits", 64'(stalls), 64'(is_err(dp) ? 1 : (sel ? 1 : 0)));
                    check("xfer_resp", 64'(rsp), 64'(is_err(dp)));
                    if (!dp.wr && !is_err(dp)) begin
                        check("read_data", rd, mem_m[sel][word_of(dp)]);
                        last_rdata = rd;
                        rd_log.push_back(rd);
                    end
                end
            end else begin
                check("idle_ready", 64'(rdy), 64'd1);
                check("idle_resp", 64'(rsp), 64'd0);
                check("idle_rdata", rd, 64'd0);
            end
            @(posedge clk); #1;
            if (rdy) begin
                if (dp_v && dp.wr && !is_err(dp)) model_write(dp);
                dp_v = addr_xfer;
                if (addr_xfer) begin dp = cur; have_cur = 0; stalls = 0; end
                stalled = 0;
            end else begin
                stalled = 1;
            end
        end
        check("run_bounded", 64'(cycles < 20000), 64'd1);
        h_sel = 1'b1; h_trans = HTRANS_IDLE;
    endtask

    task automatic random_ops(input int n);
        logic [63:0] a;
        logic [2:0]  sz;
        for (int i = 0; i < n; i++) begin
            a  = 64'($urandom_range(0, 4095));
            sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            if ($urandom_range(0, 4) != 0 && sz <= 3'd3) a = a & ~((64'd1 << sz) - 64'd1);
            push(a, 1'($urandom_range(0, 1)), sz, {$urandom, $urandom},
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2));
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) for (int w = 0; w < 256; w++) mem_m[s][w] = '0;

        // Reset values while reset is held.
        @(posedge clk); @(negedge clk);
        check("rst_ready1", 64'(ro1), 64'd1);
        check("rst_resp1", 64'(rs1), 64'd0);
        check("rst_rdata1", rd1, 64'd0);
        check("rst_ready0", 64'(ro0), 64'd1);
        check("rst_rdata0", rd0, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Define every word of both memories.
        for (int s = 1; s >= 0; s--) begin
            sel = 1'(s);
            for (int w = 0; w < 256; w++) push(64'(w * 8), 1'b1, HSIZE_DWORD, {$urandom, $urandom}, 0);
            run_ops();
        end

        // One wait state on write and read.
        sel = 1'b1;
        push(64'h10, 1'b1, HSIZE_DWORD, 64'hDEADBEEF_CAFEF00D, 0);
        push(64'h10, 1'b0, HSIZE_DWORD, 64'h0, 0);
        run_ops();
        check("ws1_rdata", last_rdata, 64'hDEADBEEF_CAFEF00D);
        check("ws1_stalls", 64'(stall_total), 64'd2);

        // Zero wait states, back-to-back.
        sel = 1'b0;
        rd_log.delete();
        push(64'h0,  1'b1, HSIZE_DWORD, 64'h1111_2222_3333_4444, 0);
        push(64'h8,  1'b1, HSIZE_DWORD, 64'h5555_6666_7777_8888, 0);
        push(64'h10, 1'b1, HSIZE_DWORD, 64'h9999_AAAA_BBBB_CCCC, 0);
        push(64'h0,  1'b0, HSIZE_DWORD, 64'h0, 0);
        push(64'h8,  1'b0, HSIZE_DWORD, 64'h0, 0);
        push(64'h10, 1'b0, HSIZE_DWORD, 64'h0, 0);
        run_ops();
        check("ws0_stalls", 64'(stall_total), 64'd0);
        check("ws0_nreads", 64'(rd_log.size()), 64'd3);
        if (rd_log.size() == 3) begin
            check("ws0_rd0", rd_log[0], 64'h1111_2222_3333_4444);
            check("ws0_rd1", rd_log[1], 64'h5555_6666_7777_8888);
            check("ws0_rd2", rd_log[2], 64'h9999_AAAA_BBBB_CCCC);
        end

        // Single byte lane write.
        sel = 1'b1;
        push(64'h20, 1'b1, HSIZE_DWORD, 64'h0, 0);
        push(64'h23, 1'b1, HSIZE_BYTE, 64'h1122_3344_AB66_7788, 0);
        push(64'h20, 1'b0, HSIZE_DWORD, 64'h0, 0);
        run_ops();
        check("byte_lane", last_rdata, 64'h0000_0000_AB00_0000);

        // Idle/busy/deselected cycles leave memory alone.
        push(64'h30, 1'b1, HSIZE_DWORD, 64'h0BAD_F00D_1234_5678, 0);
        push(64'h30, 1'b0, HSIZE_DWORD, 64'h0, 3);
        push(64'h30, 1'b0, HSIZE_DWORD, 64'h0, 3);
        run_ops();
        check("idle_mem", last_rdata, 64'h0BAD_F00D_1234_5678);

        // Out-of-range and misaligned accesses (errors when checking is built in).
        push(64'h800, 1'b0, HSIZE_DWORD, 64'h0, 0);
        push(64'h4,   1'b0, HSIZE_DWORD, 64'h0, 0);
        push(64'h8,   1'b0, HSIZE_DWORD, 64'h0, 0);
        run_ops();

        // Reset during WAIT discards the write.
        h_sel = 1'b1; h_trans = HTRANS_NONSEQ; h_addr = 64'h18; h_write = 1'b1; h_size = HSIZE_DWORD;
        @(posedge clk); #1;
        h_trans = HTRANS_IDLE; h_wdata = 64'hFFEE_DDCC_BBAA_9988;
        @(negedge clk);
        check("pre_rst_wait", 64'(ro1), 64'd0);
        rst = 1'b1; #1;
        check("async_rst_ready", 64'(ro1), 64'd1);
        check("async_rst_resp", 64'(rs1), 64'd0);
        check("async_rst_rdata", rd1, 64'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        push(64'h18, 1'b0, HSIZE_DWORD, 64'h0, 0);
        run_ops();
        check("rst_kept_mem", last_rdata, mem_m[1][3]);

        // Randomized traffic on both responders.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            random_ops(300);
            run_ops();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
